// File: rtl/contador_pkg.sv
// Shared definitions for the contador counter family.
// Contents:
//   clog2()            ceiling log2 of a positive integer, 0 for 1
//   CONTADOR_MIN_BITS  smallest legal counter width
//   CONTADOR_MAX_BITS  largest legal counter width
//   DIR_UP / DIR_DOWN  encodings of the Up input
package contador_pkg;

  localparam int CONTADOR_MIN_BITS = 2;
  localparam int CONTADOR_MAX_BITS = 32;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Number of bits needed to hold the values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/contador_prescaler.sv
// Step-tick prescaler for contador_mod.
// Counts enabled cycles 0..PRESCALE-1 and raises tick on the last one, at
// which point the internal count wraps to 0. Holds while Enable is low.
// Ports:
//   NEclk   in  clock, state updates on the falling edge
//   Nreset  in  asynchronous active-low reset
//   Enable  in  count enable
//   Clear   in  synchronous zeroing (the top drives Clear | Load here)
//   tick    out combinational: Enable and prescaler at its last value
module contador_prescaler
  import contador_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic NEclk,
  input  logic Nreset,
  input  logic Enable,
  input  logic Clear,
  output logic tick
);

  localparam int W = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] pre_cnt;
  logic         at_last;

  assign at_last = (pre_cnt == LAST);
  assign tick    = Enable & at_last;

  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      pre_cnt <= '0;
    end else if (Clear) begin
      pre_cnt <= '0;
    end else if (Enable) begin
      if (at_last) pre_cnt <= '0;
      else         pre_cnt <= pre_cnt + ONE;
    end
  end

endmodule

// File: rtl/contador_mod.sv
// Programmable-modulus up/down counter with synchronous clear and load and a
// registered terminal-count pulse for cascading digit/timebase stages.
// Counts 0..Modulus-1 (Modulus=0 selects the full 2^BITS range). All state
// changes on the falling edge of NEclk.
// Configuration macro: CONTADOR_PRESCALE_EN -- when defined, a prescaler
// divides Enable so that one step happens every PRESCALE enabled cycles.
// Ports:
//   NEclk      in  clock, falling-edge active
//   Nreset     in  asynchronous active-low reset
//   Enable     in  count enable
//   Clear      in  synchronous clear (highest synchronous priority)
//   Load       in  synchronous load of LoadValue (no range check)
//   LoadValue  in  value for Load
//   Up         in  1 = up, 0 = down
//   Modulus    in  count range; 0 = full range
//   count      out registered count
//   tc         out registered terminal-count pulse, one cycle per wrap
module contador_mod
  import contador_pkg::*;
#(
  parameter int BITS     = 29,
  parameter int PRESCALE = 1
) (
  input  logic            NEclk,
  input  logic            Nreset,
  input  logic            Enable,
  input  logic            Clear,
  input  logic            Load,
  input  logic [BITS-1:0] LoadValue,
  input  logic            Up,
  input  logic [BITS-1:0] Modulus,
  output logic [BITS-1:0] count,
  output logic            tc
);

  localparam logic [BITS-1:0] ONE = BITS'(1);

  if (BITS < CONTADOR_MIN_BITS || BITS > CONTADOR_MAX_BITS) begin : g_bad_bits
    $error("contador_mod: BITS out of range");
  end
  if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_prescale
    $error("contador_mod: PRESCALE out of range");
  end

  logic            tick;
  logic [BITS-1:0] top_val;
  logic [BITS-1:0] next_count;
  logic            next_tc;

`ifdef CONTADOR_PRESCALE_EN
  // Load also restarts the prescaler period.
  contador_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .NEclk  (NEclk),
    .Nreset (Nreset),
    .Enable (Enable),
    .Clear  (Clear | Load),
    .tick   (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // Highest legal count; Modulus=0 wraps naturally to all-ones.
  assign top_val = (Modulus == '0) ? '1 : (Modulus - ONE);

  always_comb begin
    next_count = count;
    next_tc    = 1'b0;
    if (Clear) begin
      next_count = '0;
    end else if (Load) begin
      next_count = LoadValue;
    end else if (Enable && tick) begin
      if (Up == DIR_UP) begin
        // >= rather than == so an out-of-range value wraps on the next step.
        if (count >= top_val) begin
          next_count = '0;
          next_tc    = 1'b1;
        end else begin
          next_count = count + ONE;
        end
      end else begin
        if (count == '0) begin
          next_count = top_val;
          next_tc    = 1'b1;
        end else if (count > top_val) begin
          // Out of range going down: snap into range without a wrap pulse.
          next_count = top_val;
        end else begin
          next_count = count - ONE;
        end
      end
    end
  end

  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= next_count;
      tc    <= next_tc;
    end
  end

endmodule

// File: tb/tb_contador_mod.sv
// Self-checking bench for contador_mod: a 4-bit instance, a 29-bit instance
// and a 4-bit PRESCALE=3 instance share the control inputs; each is checked
// after every falling edge against an arithmetic reference model.
module tb_contador_mod;

  localparam int P4P =
`ifdef CONTADOR_PRESCALE_EN
    3;
`else
    1;
`endif

  logic        NEclk;
  logic        Nreset;
  logic        en, clr, ld, up;
  logic [3:0]  lv4, mod4;
  logic [28:0] lv29, mod29;
  logic [3:0]  cnt4, cnt4p;
  logic        tc4, tc4p;
  logic [28:0] cnt29;
  logic        tc29;

  int n_chk;
  int n_bad;

  // reference model state
  longint m4_cnt, m29_cnt, m4p_cnt;
  bit     m4_tc, m29_tc, m4p_tc;
  int     m4_pre, m29_pre, m4p_pre;

  contador_mod #(.BITS(4), .PRESCALE(1)) u_d4 (
    .NEclk(NEclk), .Nreset(Nreset), .Enable(en), .Clear(clr), .Load(ld),
    .LoadValue(lv4), .Up(up), .Modulus(mod4), .count(cnt4), .tc(tc4)
  );

  contador_mod #(.BITS(29), .PRESCALE(1)) u_d29 (
    .NEclk(NEclk), .Nreset(Nreset), .Enable(en), .Clear(clr), .Load(ld),
    .LoadValue(lv29), .Up(up), .Modulus(mod29), .count(cnt29), .tc(tc29)
  );

  contador_mod #(.BITS(4), .PRESCALE(3)) u_d4p (
    .NEclk(NEclk), .Nreset(Nreset), .Enable(en), .Clear(clr), .Load(ld),
    .LoadValue(lv4), .Up(up), .Modulus(mod4), .count(cnt4p), .tc(tc4p)
  );

  // clock / reset
  initial begin
    NEclk = 1'b1;
    forever #5 NEclk = ~NEclk;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Counter behaviour in terms of the range 0..span-1.
  task automatic model_inst(input int bits, input int p, input longint modv,
                            input longint lv, inout longint cnt, inout bit tc,
                            inout int pre);
    longint span, last;
    span = (modv == 0) ? (longint'(1) << bits) : modv;
    last = span - 1;
    tc = 1'b0;
    if (clr) begin
      cnt = 0; pre = 0;
    end else if (ld) begin
      cnt = lv; pre = 0;
    end else if (en) begin
      if (pre < p - 1) begin
        pre = pre + 1;
      end else begin
        pre = 0;
        if (up) begin
          if (cnt >= last) begin cnt = 0; tc = 1'b1; end
          else cnt = cnt + 1;
        end else begin
          if (cnt == 0) begin cnt = last; tc = 1'b1; end
          else if (cnt > last) cnt = last;
          else cnt = cnt - 1;
        end
      end
    end
  endtask

  task automatic model_reset();
    m4_cnt = 0;  m4_tc = 0;  m4_pre = 0;
    m29_cnt = 0; m29_tc = 0; m29_pre = 0;
    m4p_cnt = 0; m4p_tc = 0; m4p_pre = 0;
  endtask

  task automatic compare_all();
    check("d4.count", cnt4, m4_cnt);
    check("d4.tc", tc4, m4_tc);
    check("d29.count", cnt29, m29_cnt);
    check("d29.tc", tc29, m29_tc);
    check("d4p.count", cnt4p, m4p_cnt);
    check("d4p.tc", tc4p, m4p_tc);
  endtask

  // driver: one falling edge, model update, sample 1 time unit later
  task automatic step_clk();
    @(negedge NEclk);
    if (!Nreset) model_reset();
    else begin
      model_inst(4, 1, longint'(mod4), longint'(lv4), m4_cnt, m4_tc, m4_pre);
      model_inst(29, 1, longint'(mod29), longint'(lv29), m29_cnt, m29_tc, m29_pre);
      model_inst(4, P4P, longint'(mod4), longint'(lv4), m4p_cnt, m4p_tc, m4p_pre);
    end
    #1;
    compare_all();
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    Nreset = 1'b0;
    en = 0; clr = 0; ld = 0; up = 1;
    lv4 = 0; mod4 = 0; lv29 = 0; mod29 = 0;
    model_reset();
    #2;
    check("reset.count", cnt4, 0);
    check("reset.tc", tc4, 0);
    @(posedge NEclk);
    Nreset = 1'b1;

    // up wrap at Modulus=10
    mod4 = 4'd10; up = 1; en = 1; clr = 1;
    step_clk();
    clr = 0;
    repeat (9) step_clk();
    check("upwrap.9.count", cnt4, 9);
    check("upwrap.9.tc", tc4, 0);
    step_clk();
    check("upwrap.10.count", cnt4, 0);
    check("upwrap.10.tc", tc4, 1);
    step_clk();
    check("upwrap.11.count", cnt4, 1);
    check("upwrap.11.tc", tc4, 0);

    // asynchronous reset mid-count
    ld = 1; lv4 = 4'd7; step_clk();
    ld = 0; en = 0; step_clk();
    check("midreset.pre", cnt4, 7);
    @(posedge NEclk);
    #1 Nreset = 1'b0;
    #1;
    model_reset();
    check("midreset.count", cnt4, 0);
    check("midreset.tc", tc4, 0);
    en = 1;
    repeat (3) step_clk();
    check("midreset.hold", cnt4, 0);
    @(posedge NEclk);
    Nreset = 1'b1;

    // down wrap at Modulus=6
    mod4 = 4'd6; up = 0; en = 1; ld = 1; lv4 = 0;
    step_clk();
    ld = 0;
    step_clk();
    check("down.wrap.count", cnt4, 5);
    check("down.wrap.tc", tc4, 1);
    step_clk();
    check("down.next.count", cnt4, 4);
    check("down.next.tc", tc4, 0);
    ld = 1; lv4 = 4'd12; step_clk();
    ld = 0; step_clk();
    check("down.oor.count", cnt4, 5);
    check("down.oor.tc", tc4, 0);

    // priority and out-of-range load going up
    clr = 1; ld = 1; en = 1; lv4 = 4'd9; step_clk();
    check("prio.clear", cnt4, 0);
    clr = 0; ld = 1; lv4 = 4'd13; mod4 = 4'd10; up = 1; step_clk();
    check("load13.count", cnt4, 13);
    ld = 0; step_clk();
    check("load13.wrap.count", cnt4, 0);
    check("load13.wrap.tc", tc4, 1);

    // Modulus=1
    mod4 = 4'd1; up = 1; step_clk(); step_clk();
    check("mod1.up.tc", tc4, 1);
    up = 0; step_clk();
    check("mod1.down.count", cnt4, 0);
    check("mod1.down.tc", tc4, 1);

    // full range on the 29-bit instance
    mod29 = '0; lv29 = '1; up = 1; ld = 1; step_clk();
    ld = 0; step_clk();
    check("full.count", cnt29, 0);
    check("full.tc", tc29, 1);
    en = 0;
    for (int i = 0; i < 5; i++) begin
      step_clk();
      check("full.hold.count", cnt29, 0);
      check("full.hold.tc", tc29, 0);
    end

`ifdef CONTADOR_PRESCALE_EN
    // prescaler period 3 at Modulus=4
    mod4 = 4'd4; up = 1; en = 1; clr = 1; step_clk();
    clr = 0;
    for (int i = 1; i <= 12; i++) begin
      step_clk();
      if (i % 3 == 0) check("pre.count", cnt4p, (i / 3) % 4);
      check("pre.tc", tc4p, (i == 12) ? 1 : 0);
    end
    clr = 1; step_clk();
    clr = 0; en = 1; step_clk();
    en = 0; step_clk(); step_clk();
    en = 1; step_clk();
    check("pre.delay.before", cnt4p, 0);
    step_clk();
    check("pre.delay.after", cnt4p, 1);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      ld  = ($urandom_range(0, 15) == 0);
      up  = $urandom_range(0, 1);
      lv4 = 4'($urandom_range(0, 15));
      lv29 = ($urandom_range(0, 3) == 0) ? '1 : 29'($urandom);
      if ($urandom_range(0, 19) == 0) mod4 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 2))
          0: mod29 = '0;
          1: mod29 = 29'($urandom_range(1, 20));
          default: mod29 = 29'($urandom);
        endcase
      end
      step_clk();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
